// File: rtl/div_if.sv
// Handshake bundle between the EX stage (master) and the multi-cycle divider (slave).
interface div_if #(
    parameter int WIDTH = 32
);
    logic                 signed_div;
    logic [WIDTH-1:0]     opdata1;
    logic [WIDTH-1:0]     opdata2;
    logic                 start;
    logic                 annul;
    logic [2*WIDTH-1:0]   result;
    logic                 ready;

    modport master (
        output signed_div, opdata1, opdata2, start, annul,
        input  result, ready
    );

    modport slave (
        input  signed_div, opdata1, opdata2, start, annul,
        output result, ready
    );
endinterface

// File: rtl/div_unit.sv
// Restoring radix-2 divider for DIV/DIVU: one quotient bit per cycle, MSB first,
// returns {remainder, quotient} with signed fix-up applied on completion.
//
//  state     | meaning
//  ST_FREE   | idle, waiting for start without annul
//  ST_BYZERO | divisor was zero; short fixed wait before answering 0
//  ST_ON     | iterating, cnt counts quotient bits produced
//  ST_END    | result valid, held until start drops or annul
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic clk,
    input  logic rst,
    div_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {ST_FREE, ST_BYZERO, ST_ON, ST_END} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   divisor;
    logic [WIDTH-1:0]   dvd;
    logic [WIDTH-1:0]   rem;
    logic               neg_q;
    logic               neg_r;
    logic [2*WIDTH-1:0] result;
    logic               ready;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     trial;
    logic [WIDTH:0]     diff;
    logic               ge;
    logic               stop;

    assign bus.result = result;
    assign bus.ready  = ready;

    always_comb begin
        a_neg = bus.signed_div & bus.opdata1[WIDTH-1];
        b_neg = bus.signed_div & bus.opdata2[WIDTH-1];
        abs_a = a_neg ? (~bus.opdata1 + 1'b1) : bus.opdata1;
        abs_b = b_neg ? (~bus.opdata2 + 1'b1) : bus.opdata2;
        trial = {rem, dvd[WIDTH-1]};
        // rem < divisor always holds, so the top bit of diff is a clean borrow flag
        diff  = trial - {1'b0, divisor};
        ge    = ~diff[WIDTH];
        stop  = bus.annul | ~bus.start;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_FREE;
            cnt     <= '0;
            divisor <= '0;
            dvd     <= '0;
            rem     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            result  <= '0;
            ready   <= 1'b0;
        end else begin
            case (state)
                ST_FREE: begin
                    ready  <= 1'b0;
                    result <= '0;
                    cnt    <= '0;
                    if (bus.start && !bus.annul) begin
                        if (bus.opdata2 == '0) begin
                            state <= ST_BYZERO;
                        end else begin
                            divisor <= abs_b;
                            dvd     <= abs_a;
                            rem     <= '0;
                            neg_q   <= a_neg ^ b_neg;
                            neg_r   <= a_neg;
                            state   <= ST_ON;
                        end
                    end
                end
                ST_BYZERO: begin
                    // two edges before answering, so the zero case sees the same handshake shape
                    if (stop) begin
                        state <= ST_FREE;
                        cnt   <= '0;
                    end else if (cnt == '0) begin
                        cnt <= CW'(1);
                    end else begin
                        state  <= ST_END;
                        cnt    <= '0;
                        result <= '0;
                        ready  <= 1'b1;
                    end
                end
                ST_ON: begin
                    if (stop) begin
                        state <= ST_FREE;
                        cnt   <= '0;
                    end else if (cnt != CW'(WIDTH)) begin
                        rem <= ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
                        dvd <= {dvd[WIDTH-2:0], ge};
                        cnt <= cnt + 1'b1;
                    end else begin
                        state  <= ST_END;
                        cnt    <= '0;
                        result <= {neg_r ? (~rem + 1'b1) : rem,
                                   neg_q ? (~dvd + 1'b1) : dvd};
                        ready  <= 1'b1;
                    end
                end
                ST_END: begin
                    if (stop) begin
                        state  <= ST_FREE;
                        ready  <= 1'b0;
                        result <= '0;
                    end
                end
                default: begin
                    state <= ST_FREE;
                    ready <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: driver pushes reference results, monitor checks on ready rise.
module tb_div_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    div_if #(.WIDTH(32)) bus();
    div_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [63:0] res;
        int          e0;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic ready_q = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] ref_div(bit sd, logic [31:0] a, logic [31:0] b);
        longint sa, sbv, q, r;
        logic [63:0] q64, r64;
        if (b == 32'd0) return 64'd0;
        sa  = sd ? {{32{a[31]}}, a} : {32'd0, a};
        sbv = sd ? {{32{b[31]}}, b} : {32'd0, b};
        q   = sa / sbv;
        r   = sa % sbv;
        q64 = q;
        r64 = r;
        return {r64[31:0], q64[31:0]};
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            ready_q = 1'b0;
        end else begin
            if (bus.ready && !ready_q) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready: got ready=1 result=%h expected no result", bus.result);
                end else begin
                    e = sb.pop_front();
                    chk("result", bus.result, e.res);
                    chk("latency", 64'(cyc - e.e0), 64'(e.lat));
                end
            end
            ready_q = bus.ready;
        end
    end

    task automatic run_div(bit sd, logic [31:0] a, logic [31:0] b, int hold);
        exp_t e;
        int   n;
        @(negedge clk);
        bus.signed_div = sd;
        bus.opdata1    = a;
        bus.opdata2    = b;
        bus.start      = 1'b1;
        bus.annul      = 1'b0;
        e.res = ref_div(sd, a, b);
        e.e0  = cyc + 1;
        e.lat = (b == 32'd0) ? 2 : 33;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.opdata1    = $urandom;
        bus.opdata2    = $urandom;
        bus.signed_div = 1'($urandom_range(0, 1));
        n = 0;
        while (!bus.ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got ready=0 after %0d cycles expected ready", n);
        end
        repeat (hold) @(negedge clk);
        chk("hold_ready", 64'(bus.ready), 64'd1);
        chk("hold_result", bus.result, e.res);
        bus.start = 1'b0;
        @(negedge clk);
        chk("drop_ready", 64'(bus.ready), 64'd0);
        chk("drop_result", bus.result, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        bit          sd;
        int          mode;
        exp_t        e;
        int          n;

        bus.signed_div = 1'b0;
        bus.opdata1    = '0;
        bus.opdata2    = '0;
        bus.start      = 1'b0;
        bus.annul      = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ready", 64'(bus.ready), 64'd0);
        chk("reset_result", bus.result, 64'd0);
        rst = 1'b1;

        run_div(0, 32'd7, 32'd2, 1);
        run_div(1, 32'hFFFFFFF9, 32'd2, 0);
        run_div(1, 32'd7, 32'hFFFFFFFE, 2);
        run_div(0, 32'hFFFFFFFF, 32'd1, 0);
        run_div(1, 32'h80000000, 32'hFFFFFFFF, 1);
        run_div(0, 32'd5, 32'd0, 1);
        run_div(1, 32'hFFFFFFFB, 32'd0, 0);

        // annul after ten quotient bits, then restart
        @(negedge clk);
        bus.signed_div = 1'b0;
        bus.opdata1    = 32'd12345;
        bus.opdata2    = 32'd7;
        bus.start      = 1'b1;
        repeat (11) @(negedge clk);
        bus.annul = 1'b1;
        @(negedge clk);
        bus.annul = 1'b0;
        bus.start = 1'b0;
        chk("annul_ready", 64'(bus.ready), 64'd0);
        run_div(0, 32'd100, 32'd7, 1);

        // start dropped mid-divide
        @(negedge clk);
        bus.opdata1 = 32'd999;
        bus.opdata2 = 32'd4;
        bus.start   = 1'b1;
        repeat (20) @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        chk("stopdrop_ready", 64'(bus.ready), 64'd0);

        // async reset mid-divide
        @(negedge clk);
        bus.opdata1 = 32'd50;
        bus.opdata2 = 32'd3;
        bus.start   = 1'b1;
        repeat (6) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_on_ready", 64'(bus.ready), 64'd0);
        chk("rst_on_result", bus.result, 64'd0);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // async reset while a result is being held
        @(negedge clk);
        bus.signed_div = 1'b0;
        bus.opdata1    = 32'd40;
        bus.opdata2    = 32'd6;
        bus.start      = 1'b1;
        e.res = ref_div(0, 32'd40, 32'd6);
        e.e0  = cyc + 1;
        e.lat = 33;
        sb.push_back(e);
        n = 0;
        while (!bus.ready && n < 45) begin
            @(negedge clk);
            n++;
        end
        chk("pre_rst_ready", 64'(bus.ready), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("rst_end_ready", 64'(bus.ready), 64'd0);
        chk("rst_end_result", bus.result, 64'd0);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_div(0, 32'd9, 32'd3, 0);

        for (int i = 0; i < 24; i++) begin
            sd   = 1'($urandom_range(0, 1));
            a    = $urandom;
            mode = $urandom_range(0, 7);
            case (mode)
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'hFFFFFFFF;
                3:       begin b = $urandom; a = 32'h80000000; end
                default: b = $urandom;
            endcase
            run_div(sd, a, b, $urandom_range(0, 3));
        end

        repeat (3) @(negedge clk);
        chk("drain", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
